// File: rtl/bitrev_perm_ctrl.sv
// -----------------------------------------------------------------------------
// bitrev_perm_ctrl
//
// Address sequencer for an out-of-place bit-reversal permutation of one
// N = 2^LOGN coefficient polynomial. Natural-order reads are issued to the
// source bank. A fixed-latency delay line carries each read address forward,
// so the destination-bank write for coefficient i lands at bitrev(i) in the
// same cycle that the read data comes back. No coefficient data passes
// through this block.
//
// Parameters:
//   LOGN    log2 of polynomial length (address width), LOGN >= 2
//   RD_LAT  source read latency, rd_en to data valid, 1..8 cycles
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   single-cycle request to begin a permutation (ignored while busy)
//   hold     in   pauses issue of new reads while high (ISSUE state only)
//   busy     out  high from the cycle after an accepted start until done
//   done     out  one-cycle pulse after the final write
//   rd_en    out  source-bank read enable
//   rd_addr  out  source-bank read address, natural order
//   wr_en    out  destination-bank write enable, aligned with read data
//   wr_addr  out  destination-bank write address, bitrev of matching rd_addr
// -----------------------------------------------------------------------------
module bitrev_perm_ctrl #(
  parameter int LOGN   = 10,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [LOGN-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [LOGN-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [LOGN-1:0]   rd_addr_q, rd_addr_d;

  // Delay line: stage RD_LAT-1 is the write-side output register.
  logic [RD_LAT-1:0] vld_q;
  logic [LOGN-1:0]   addr_q [RD_LAT];
  logic [RD_LAT-1:0] vld_inner;
  logic              pending;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int k = 0; k < LOGN; k++) begin
      r[k] = a[LOGN-1-k];
    end
    return r;
  endfunction

  // Anything that will still be valid in the delay line after the next shift.
  // The output stage is excluded: its entry is being written this cycle, so
  // once only it remains the run finishes one cycle after the last write.
  assign vld_inner = vld_q << 1;
  assign pending   = rd_en_q | (|vld_inner);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!hold) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q;
          cnt_d     = cnt_q + 1'b1;  // wraps to 0 on the final issue
          if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pending) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // The delay line shifts every cycle regardless of hold: memory latency is
  // fixed, so a stall here would misalign writes from their read data.
  // The address is reversed on entry; reversal is pure wiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= rd_en_q;
      addr_q[0] <= bitrev(rd_addr_q);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = vld_q[RD_LAT-1];
  assign wr_addr = addr_q[RD_LAT-1];

endmodule

// File: tb/tb_bitrev_perm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitrev_perm_ctrl
//
// Three instances of bitrev_perm_ctrl in different configurations:
//   u0: LOGN=3,  RD_LAT=2  directed runs (hold gap, ignored starts, abort)
//   u1: LOGN=4,  RD_LAT=1  back-to-back runs
//   u2: LOGN=10, RD_LAT=3  random hold, data scoreboard through a memory model
// A transaction-level reference (run flag, issue count, queue of pending
// writes with due cycles) predicts every output each cycle; literal
// sequences pin the reference for the small configurations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bitrev_perm_ctrl;

  localparam int NG = 3;
  localparam int LOGN_G [NG] = '{3, 4, 10};
  localparam int LAT_G  [NG] = '{2, 1, 3};
  localparam int LIT8   [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  localparam int LIT16  [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  localparam int BUSY0  [4]  = '{11, 14, 11, 11};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NG-1:0] rstn_v, start_v, hold_v;
  logic [NG-1:0] busy_v, done_v, rden_v, wren_v;
  logic [2:0] ra0, wa0;
  logic [3:0] ra1, wa1;
  logic [9:0] ra2, wa2;

  bitrev_perm_ctrl #(.LOGN(3), .RD_LAT(2)) u0 (
    .clk(clk), .rst_n(rstn_v[0]), .start(start_v[0]), .hold(hold_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .rd_en(rden_v[0]), .rd_addr(ra0),
    .wr_en(wren_v[0]), .wr_addr(wa0));

  bitrev_perm_ctrl #(.LOGN(4), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rstn_v[1]), .start(start_v[1]), .hold(hold_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .rd_en(rden_v[1]), .rd_addr(ra1),
    .wr_en(wren_v[1]), .wr_addr(wa1));

  bitrev_perm_ctrl #(.LOGN(10), .RD_LAT(3)) u2 (
    .clk(clk), .rst_n(rstn_v[2]), .start(start_v[2]), .hold(hold_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .rd_en(rden_v[2]), .rd_addr(ra2),
    .wr_en(wren_v[2]), .wr_addr(wa2));

  function automatic int rev(input int v, input int w);
    int r = 0;
    for (int k = 0; k < w; k++) begin
      if (v[k]) r |= (1 << (w - 1 - k));
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int gi;
    int due;
    int addr;
  } pend_t;

  pend_t pq[$];
  int    cyc = 0;
  bit    m_act    [NG];
  bit    m_indone [NG];
  int    m_issued [NG];
  bit    e_rd_en  [NG];
  bit    e_wr_en  [NG];
  bit    e_done   [NG];
  int    e_rd_addr[NG];
  int    e_wr_addr[NG];

  function automatic bit has_pending(input int g);
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i].gi == g) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit was_act;
    bit was_done;
    int hit;
    cyc++;
    for (int g = 0; g < NG; g++) begin
      if (!rstn_v[g]) begin
        m_act[g] = 0; m_indone[g] = 0; m_issued[g] = 0;
        e_rd_en[g] = 0; e_wr_en[g] = 0; e_done[g] = 0;
        e_rd_addr[g] = 0; e_wr_addr[g] = 0;
        for (int i = pq.size() - 1; i >= 0; i--) begin
          if (pq[i].gi == g) pq.delete(i);
        end
      end else begin
        was_act  = m_act[g];
        was_done = m_indone[g];
        e_rd_en[g] = 0; e_wr_en[g] = 0; e_done[g] = 0;
        hit = -1;
        for (int i = 0; i < pq.size(); i++) begin
          if (hit < 0 && pq[i].gi == g && pq[i].due == cyc) hit = i;
        end
        if (hit >= 0) begin
          e_wr_en[g]   = 1;
          e_wr_addr[g] = rev(pq[hit].addr, LOGN_G[g]);
          pq.delete(hit);
        end
        if (was_act && m_issued[g] < (1 << LOGN_G[g]) && !hold_v[g]) begin
          e_rd_en[g]   = 1;
          e_rd_addr[g] = m_issued[g];
          pq.push_back('{g, cyc + LAT_G[g], m_issued[g]});
          m_issued[g]++;
        end
        if (was_act && m_issued[g] == (1 << LOGN_G[g]) && !has_pending(g) && !e_wr_en[g]) begin
          e_done[g]   = 1;
          m_act[g]    = 0;
          m_indone[g] = 1;
        end
        if (!was_act) begin
          if (was_done) m_indone[g] = 0;
          else if (start_v[g]) begin
            m_act[g]    = 1;
            m_issued[g] = 0;
          end
        end
      end
    end
  end

  // ---------------- compare / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int tmo_cnt  = 0;
  int tmo_seen = 0;
  int src [1024];
  int dst [1024];
  int wcnt[1024];
  int dq[$];
  int seq0[$];
  int seq1[$];
  int bcnt[NG];
  int run0 = 0;

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got %0d expected %0d at t=%0t", g, nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [31:0] ra, wa;
    int v;
    int j;
    for (int g = 0; g < NG; g++) begin
      case (g)
        0:       begin ra = {29'd0, ra0}; wa = {29'd0, wa0}; end
        1:       begin ra = {28'd0, ra1}; wa = {28'd0, wa1}; end
        default: begin ra = {22'd0, ra2}; wa = {22'd0, wa2}; end
      endcase
      if (!rstn_v[g]) begin
        chk(g, "rst_busy", {31'd0, busy_v[g]}, 0);
        chk(g, "rst_done", {31'd0, done_v[g]}, 0);
        chk(g, "rst_rd_en", {31'd0, rden_v[g]}, 0);
        chk(g, "rst_wr_en", {31'd0, wren_v[g]}, 0);
        chk(g, "rst_rd_addr", ra, 0);
        chk(g, "rst_wr_addr", wa, 0);
        bcnt[g] = 0;
        if (g == 0) seq0.delete();
        if (g == 1) seq1.delete();
        if (g == 2) begin
          dq.delete();
          for (int i = 0; i < 1024; i++) begin wcnt[i] = 0; dst[i] = 0; end
        end
      end else begin
        chk(g, "rd_en", {31'd0, rden_v[g]}, {31'd0, e_rd_en[g]});
        chk(g, "wr_en", {31'd0, wren_v[g]}, {31'd0, e_wr_en[g]});
        chk(g, "busy", {31'd0, busy_v[g]}, {31'd0, m_act[g]});
        chk(g, "done", {31'd0, done_v[g]}, {31'd0, e_done[g]});
        if (e_rd_en[g]) chk(g, "rd_addr", ra, e_rd_addr[g]);
        if (e_wr_en[g]) chk(g, "wr_addr", wa, e_wr_addr[g]);
        if (busy_v[g]) bcnt[g]++;
        if (wren_v[g]) begin
          if (g == 0) seq0.push_back(wa);
          if (g == 1) seq1.push_back(wa);
          if (g == 2) begin
            v = (dq.size() > 0) ? dq.pop_front() : 32'hdead_beef;
            dst[wa] = v;
            wcnt[wa]++;
          end
        end
        if (rden_v[g] && g == 2) dq.push_back(src[ra]);
        if (done_v[g]) begin
          if (g == 0) begin
            chk(g, "busy_cycles", bcnt[g], BUSY0[(run0 < 4) ? run0 : 3]);
            chk(g, "write_count", seq0.size(), 8);
            for (int i = 0; i < 8; i++) chk(g, "wr_seq_lit", seq0[i], LIT8[i]);
            run0++;
            seq0.delete();
          end else if (g == 1) begin
            chk(g, "busy_cycles", bcnt[g], 18);
            chk(g, "write_count", seq1.size(), 16);
            for (int i = 0; i < 16; i++) chk(g, "wr_seq_lit", seq1[i], LIT16[i]);
            seq1.delete();
          end else begin
            for (int i = 0; i < 1024; i++) begin
              j = rev(i, 10);
              chk(g, "sb_write_once", wcnt[j], 1);
              chk(g, "sb_data", dst[j], src[i]);
              wcnt[j] = 0;
              dst[j]  = 0;
            end
            dq.delete();
          end
          bcnt[g] = 0;
        end
      end
    end
    if (tmo_cnt != tmo_seen) begin
      chk(0, "wait_bound", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input int g);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int bound);
    int n = 0;
    while (!done_v[g] && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[g]) tmo_cnt++;
  endtask

  initial begin
    int n;
    rstn_v  = '0;
    start_v = '0;
    hold_v  = '0;
    for (int i = 0; i < 1024; i++) src[i] = int'($urandom);
    repeat (3) @(negedge clk);
    #2 rstn_v = '1;
    repeat (2) @(negedge clk);

    // u0: plain run, with hold toggled while idle
    hold_v[0] = 1'b1;
    @(negedge clk);
    hold_v[0] = 1'b0;
    pulse(0);
    wait_done(0, 40);
    repeat (3) @(negedge clk);

    // u0: 3-cycle hold after the 4th read
    pulse(0);
    repeat (4) @(negedge clk);
    hold_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    hold_v[0] = 1'b0;
    wait_done(0, 40);
    repeat (3) @(negedge clk);

    // u0: start mid-run and during the done cycle, both ignored
    pulse(0);
    repeat (4) @(negedge clk);
    pulse(0);
    wait_done(0, 40);
    pulse(0);
    repeat (3) @(negedge clk);

    // u0: reset during drain, then a fresh run
    pulse(0);
    repeat (9) @(negedge clk);
    #2 rstn_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstn_v[0] = 1'b1;
    @(negedge clk);
    pulse(0);
    wait_done(0, 40);
    repeat (3) @(negedge clk);

    // u1: back-to-back runs, second start the cycle after done
    pulse(1);
    wait_done(1, 40);
    @(negedge clk);
    pulse(1);
    wait_done(1, 40);
    repeat (3) @(negedge clk);

    // u2: two runs with random hold
    for (int r = 0; r < 2; r++) begin
      pulse(2);
      n = 0;
      while (!done_v[2] && n < 4000) begin
        hold_v[2] = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        n++;
      end
      hold_v[2] = 1'b0;
      if (!done_v[2]) tmo_cnt++;
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
